spi_reg_bank: RTL

//  SPI mode-0 peripheral that owns a parametrised bank of NUM_REGS control registers, each DATA_W bits wide.

---
 rtl/spi_reg_bank_pkg.sv | 5 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_reg_bank.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bank_pkg.sv
// spi_reg_bank_pkg: shared FSM state type and frame constants for the SPI register bank
package spi_reg_bank_pkg;
    typedef enum logic [1:0] {IDLE, CMD, DATA, OVER} state_e;
    localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser with one-clk rise/fall strobes on the synchronised level
module spi_sync_edge #(
    parameter int   SYNC_FF = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_FF-1:0] sync_q;
    logic               prev_q;

    // shift the pin through the chain and remember the last synchronised level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_FF{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_FF-2:0], d_i};
            prev_q <= sync_q[SYNC_FF-1];
        end
    end

    assign q_o    = sync_q[SYNC_FF-1];
    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral owning a bank of control registers with read-back
module spi_reg_bank
    import spi_reg_bank_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 8,
    parameter int SYNC_FF  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] reg_q,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
    localparam int CW        = $clog2(FRAME_LEN + 1);

    logic s_ncs, ncs_rise, ncs_fall, sclk_rise, sclk_fall, s_copi;
    logic sclk_lvl_unused, copi_rise_unused, copi_fall_unused;

    state_e                           state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [FRAME_LEN-1:0]             shift_q, shift_d, shift_nxt;
    logic                             rw_q, rw_d, ovf_q, ovf_d;
    logic [DATA_W-1:0]                rdata_q, rdata_d, rd_word;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic                             wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]                wr_addr_q, wr_addr_d, f_addr, addr_latch;
    logic [DATA_W-1:0]                f_data;
    logic                             f_rw, last_addr, first_data, last_data, full;
    logic                             addr_ok, wr_ok, bad;

    spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b0)) u_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi),
        .q_o(s_copi), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
    );
    spi_sync_edge #(.SYNC_FF(SYNC_FF), .RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs),
        .q_o(s_ncs), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NUM_REGS;
    endfunction

    // frame fields are only meaningful once bit_cnt reaches FRAME_LEN, which every commit requires
    assign shift_nxt  = {shift_q[FRAME_LEN-2:0], s_copi};
    assign addr_latch = shift_nxt[ADDR_W-1:0];
    assign f_rw       = shift_q[FRAME_LEN-1];
    assign f_addr     = shift_q[FRAME_LEN-2 -: ADDR_W];
    assign f_data     = shift_q[DATA_W-1:0];
    assign last_addr  = cnt_q == CW'(ADDR_W);
    assign first_data = cnt_q == CW'(ADDR_W + 1);
    assign last_data  = cnt_q == CW'(FRAME_LEN - 1);
    assign full       = cnt_q == CW'(FRAME_LEN);
    assign addr_ok    = in_range(f_addr);
    assign wr_ok      = full & ~ovf_q & (f_rw == RW_WRITE) & addr_ok;
    assign bad        = ~full | ovf_q | ((f_rw == RW_WRITE) & ~addr_ok);

    // read mux; out-of-range addresses fall through to zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (addr_latch == ADDR_W'(i)) rd_word = regs_q[i];
    end

    // register bank write port, committed only by a clean write frame
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++)
            if (ncs_rise && wr_ok && f_addr == ADDR_W'(i)) regs_d[i] = f_data;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; ncs_rise overrides everything
    always_comb begin
        state_d = ncs_rise                                        ? IDLE :
                  (state_q == IDLE && ncs_fall)                   ? CMD  :
                  (state_q == CMD  && sclk_rise && last_addr)     ? DATA :
                  (state_q == DATA && sclk_rise && last_data)     ? OVER : state_q;
    end

    // FSM outputs: shifting, address latch, read serialisation and commit strobes
    always_comb begin
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        ovf_d       = ovf_q;
        rdata_d     = rdata_q;
        wr_stb_d    = ncs_rise & wr_ok;
        wr_addr_d   = (ncs_rise & wr_ok) ? f_addr : wr_addr_q;
        frame_err_d = ncs_rise & bad;
        if (ncs_rise) begin
            cnt_d   = '0;
            ovf_d   = 1'b0;
            rdata_d = '0;
        end else if (state_q == IDLE && ncs_fall) begin
            cnt_d   = '0;
            shift_d = '0;
            rw_d    = 1'b0;
            ovf_d   = 1'b0;
            rdata_d = '0;
        end else if ((state_q == CMD || state_q == DATA) && sclk_rise) begin
            cnt_d   = cnt_q + CW'(1);
            shift_d = shift_nxt;
            if (state_q == CMD && last_addr) begin
                rw_d    = shift_nxt[ADDR_W];
                rdata_d = (shift_nxt[ADDR_W] == RW_WRITE) ? '0 : rd_word;
            end
        end else if (state_q == DATA && sclk_fall && rw_q != RW_WRITE && !first_data) begin
            // the fall trailing the last address bit is skipped so the MSB survives to the first data rise
            rdata_d = {rdata_q[DATA_W-2:0], 1'b0};
        end else if (state_q == OVER && sclk_rise) begin
            ovf_d = 1'b1;
        end
    end

    // datapath and register bank state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ovf_q       <= 1'b0;
            rdata_q     <= '0;
            regs_q      <= '0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            ovf_q       <= ovf_d;
            rdata_q     <= rdata_d;
            regs_q      <= regs_d;
            wr_stb_q    <= wr_stb_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign cipo      = rdata_q[DATA_W-1];
    assign cipo_oe   = ~s_ncs;
    assign reg_q     = regs_q;
    assign wr_stb    = wr_stb_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
endmodule
